// File: rtl/digital_theremin_debug_pkg.sv
// Shared types and constants for the debug-slave JTAG scan master.
package digital_theremin_debug_pkg;

    localparam int IR_W_DEF      = 2;
    localparam int DR_W_DEF      = 38;
    localparam int INIT_TCKS     = 6;
    localparam int SCAN_OVERHEAD = 10;

    // tms walks, applied bit0 first: 1,1,0,0 into a shift state and 1,0 back to idle
    localparam logic [3:0] TMS_TO_SHIFT = 4'b0011;
    localparam logic [1:0] TMS_TO_IDLE  = 2'b01;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN, ST_DONE} ctrl_state_e;

    typedef enum logic [3:0] {
        TAP_RESET, TAP_IDLE,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_e;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_RESET:    n = tms ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     n = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   n = tms ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_IDLE;
            default:      n = TAP_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/digital_theremin_cpu_debug_scan_tck_gen.sv
// Test-clock generator: tck toggles every CLK_DIV clk cycles while run is high.
// rise/fall flag the clk cycle whose closing edge moves tck 0->1 / 1->0.
module digital_theremin_cpu_debug_scan_tck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             terminal;

    assign terminal = run && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise     = terminal && !tck;
    assign fall     = terminal && tck;

    // Half-period counter and tck register; parked low whenever not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (terminal) begin
            cnt <= '0;
            tck <= !tck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digital_theremin_cpu_debug_scan_master.sv
// JTAG scan initiator: resets the TAP, then per command shifts one IR and one DR
// value LSB first and returns the tdo bits captured during each shift.
module digital_theremin_cpu_debug_scan_master
    import digital_theremin_debug_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int IR_W    = IR_W_DEF,
    parameter int DR_W    = DR_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IR_W-1:0] rsp_ir,
    output logic [DR_W-1:0] rsp_dr,
    output logic            tck,
    output logic            tms,
    output logic            tdi,
    input  logic            tdo,
    output logic            busy
);
    localparam int TOTAL = IR_W + DR_W + SCAN_OVERHEAD;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int IR_LO = 4;
    localparam int IR_HI = IR_LO + IR_W - 1;
    localparam int DR_LO = IR_HI + 5;
    localparam int DR_HI = DR_LO + DR_W - 1;

    ctrl_state_e      state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             tms_n, tdi_n, rsp_valid_n, accept;
    logic [IR_W-1:0]  ir_lat;
    logic [DR_W-1:0]  dr_lat;
    logic             run, rise, fall;

    assign run = (state == ST_INIT) || (state == ST_SCAN);

    digital_theremin_cpu_debug_scan_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tck   (tck),
        .rise  (rise),
        .fall  (fall)
    );

    function automatic logic tms_at(input int j);
        logic t;
        if (j < IR_LO) begin
            t = ((TMS_TO_SHIFT >> j) & 4'b0001) != 4'b0000;
        end else if (j <= IR_HI) begin
            t = (j == IR_HI);
        end else if (j < DR_LO) begin
            t = ((TMS_TO_SHIFT >> (j - IR_HI - 1)) & 4'b0001) != 4'b0000;
        end else if (j <= DR_HI) begin
            t = (j == DR_HI);
        end else begin
            t = ((TMS_TO_IDLE >> (j - DR_HI - 1)) & 2'b01) != 2'b00;
        end
        return t;
    endfunction

    function automatic logic tdi_at(input int j, input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
        logic t;
        if (j >= IR_LO && j <= IR_HI) begin
            t = ((ir >> (j - IR_LO)) & IR_W'(1)) != '0;
        end else if (j >= DR_LO && j <= DR_HI) begin
            t = ((dr >> (j - DR_LO)) & DR_W'(1)) != '0;
        end else begin
            t = 1'b0;
        end
        return t;
    endfunction

    // Next-state logic; tms/tdi for tck k+1 are computed on the falling edge ending tck k
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        tms_n       = tms;
        tdi_n       = tdi;
        rsp_valid_n = rsp_valid;
        accept      = 1'b0;
        case (state)
            ST_INIT: begin
                if (fall && idx == IDX_W'(INIT_TCKS - 1)) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    tms_n   = 1'b0;
                end else if (fall) begin
                    idx_n = idx + IDX_W'(1);
                    tms_n = (int'(idx) < INIT_TCKS - 2);
                end else begin
                    idx_n = idx;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_n = ST_SCAN;
                    idx_n   = '0;
                    tms_n   = tms_at(0);
                    tdi_n   = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (fall && idx == IDX_W'(TOTAL - 1)) begin
                    state_n     = ST_DONE;
                    idx_n       = '0;
                    tms_n       = 1'b0;
                    tdi_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                end else if (fall) begin
                    idx_n = idx + IDX_W'(1);
                    tms_n = tms_at(int'(idx) + 1);
                    tdi_n = tdi_at(int'(idx) + 1, ir_lat, dr_lat);
                end else begin
                    idx_n = idx;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n     = ST_INIT;
                idx_n       = '0;
                tms_n       = 1'b1;
                tdi_n       = 1'b0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    // Controller state and registered handshake/TAP outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            idx       <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            rsp_valid <= rsp_valid_n;
            cmd_ready <= (state_n == ST_IDLE);
            busy      <= (state_n != ST_IDLE);
        end
    end

    // Command latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_lat <= '0;
            dr_lat <= '0;
        end else if (accept) begin
            ir_lat <= cmd_ir;
            dr_lat <= cmd_dr;
        end else begin
            ir_lat <= ir_lat;
            dr_lat <= dr_lat;
        end
    end

    // tdo capture: enters at the MSB so the first captured bit ends up in bit0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_ir <= '0;
            rsp_dr <= '0;
        end else if (accept) begin
            rsp_ir <= '0;
            rsp_dr <= '0;
        end else if (state == ST_SCAN && rise) begin
            if (idx >= IDX_W'(IR_LO) && idx <= IDX_W'(IR_HI)) begin
                rsp_ir <= {tdo, rsp_ir[IR_W-1:1]};
            end else if (idx >= IDX_W'(DR_LO) && idx <= IDX_W'(DR_HI)) begin
                rsp_dr <= {tdo, rsp_dr[DR_W-1:1]};
            end else begin
                rsp_ir <= rsp_ir;
            end
        end else begin
            rsp_ir <= rsp_ir;
        end
    end

endmodule

// File: tb/tb_digital_theremin_cpu_debug_scan_master.sv
// Directed bench: default-divider master with loopback / TAP-model slaves, plus a CLK_DIV=3 instance.
module tb_digital_theremin_cpu_debug_scan_master;
    import digital_theremin_debug_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, tck, tms, tdi, tdo, busy;
    logic [1:0]  cmd_ir, rsp_ir;
    logic [37:0] cmd_dr, rsp_dr;

    logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, tck3, tms3, tdi3, busy3;
    logic [1:0]  cmd_ir3, rsp_ir3;
    logic [37:0] cmd_dr3, rsp_dr3;

    logic [1:0]  tdo_mode;
    logic        lb_stage;
    tap_state_e  tap;
    logic [1:0]  m_ir_sr = 2'b00;
    logic [1:0]  m_ir    = 2'b00;
    logic [37:0] m_dr_sr = 38'h0;
    logic [37:0] m_dr    = 38'h0;
    logic        model_tdo;

    int n_cmp = 0;
    int n_bad = 0;

    digital_theremin_cpu_debug_scan_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ir(rsp_ir), .rsp_dr(rsp_dr), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    digital_theremin_cpu_debug_scan_master #(.CLK_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_ir(cmd_ir3), .cmd_dr(cmd_dr3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_ir(rsp_ir3), .rsp_dr(rsp_dr3), .tck(tck3), .tms(tms3), .tdi(tdi3), .tdo(1'b1), .busy(busy3)
    );

    // 1-bit loopback stage: tdo returns tdi one tck late
    always @(posedge tck or posedge reset) begin
        if (reset) lb_stage <= 1'b0;
        else       lb_stage <= tdi;
    end

    // Behavioural TAP with 2-bit IR (capture 01) and 38-bit DR (capture 3F_0000_0001)
    always @(posedge tck or posedge reset) begin
        if (reset) begin
            tap <= TAP_RESET;
        end else begin
            case (tap)
                TAP_CAP_IR:   m_ir_sr <= 2'b01;
                TAP_SHIFT_IR: m_ir_sr <= {tdi, m_ir_sr[1]};
                TAP_UPD_IR:   m_ir    <= m_ir_sr;
                TAP_CAP_DR:   m_dr_sr <= 38'h3F_0000_0001;
                TAP_SHIFT_DR: m_dr_sr <= {tdi, m_dr_sr[37:1]};
                TAP_UPD_DR:   m_dr    <= m_dr_sr;
                default:      ;
            endcase
            tap <= tap_next(tap, tms);
        end
    end

    assign model_tdo = (tap == TAP_SHIFT_IR) ? m_ir_sr[0] : m_dr_sr[0];
    assign tdo = (tdo_mode == 2'd1) ? lb_stage : ((tdo_mode == 2'd2) ? model_tdo : 1'b0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        int r1;
        int r2;
        logic p_tck, p_tms, p_tdi;

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = 38'h0; rsp_ready = 1'b0; tdo_mode = 2'd0;
        cmd_valid3 = 1'b0; cmd_ir3 = 2'b00; cmd_dr3 = 38'h0; rsp_ready3 = 1'b0;
        repeat (3) tick();

        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_ir", 64'(rsp_ir), 64'd0);
        chk("rst_rsp_dr", 64'(rsp_dr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);

        // INIT: tck rises on odd cycles, tms 1,1,1,1,1,0, ready at cycle 12
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 2 == 1) begin
                chk("init_tck", 64'(tck), 64'd1);
                chk("init_tms", 64'(tms), 64'(c < 11));
            end
            chk("init_ready", 64'(cmd_ready), 64'(c == 12));
        end
        chk("init_busy", 64'(busy), 64'd0);

        // Loopback scan
        tdo_mode = 2'd1; cmd_ir = 2'b10; cmd_dr = 38'h2A_5A5A_5A5A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("acc_busy", 64'(busy), 64'd1);
        chk("acc_ready", 64'(cmd_ready), 64'd0);
        lat = 0;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        chk("lb_latency", 64'(lat), 64'd100);
        chk("lb_rsp_ir", 64'(rsp_ir), 64'd0);
        chk("lb_rsp_dr", 64'(rsp_dr), 64'h14_B4B4_B4B4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("lb_ack_valid", 64'(rsp_valid), 64'd0);
        chk("lb_ack_ready", 64'(cmd_ready), 64'd1);
        chk("lb_ack_busy", 64'(busy), 64'd0);

        // TAP model scan; a second command is presented while busy
        tdo_mode = 2'd2; cmd_ir = 2'b11; cmd_dr = 38'h15_1234_5678; cmd_valid = 1'b1;
        tick();
        cmd_ir = 2'b00; cmd_dr = 38'h00_0F0F_F0F0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        chk("tap_latency", 64'(lat), 64'd100);
        chk("tap_rsp_ir", 64'(rsp_ir), 64'h1);
        chk("tap_rsp_dr", 64'(rsp_dr), 64'h3F_0000_0001);
        chk("tap_model_ir", 64'(m_ir), 64'h3);
        chk("tap_model_dr", 64'(m_dr), 64'h15_1234_5678);

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_ready", 64'(cmd_ready), 64'd0);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_dr", 64'(rsp_dr), 64'h3F_0000_0001);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hs_valid", 64'(rsp_valid), 64'd0);
        chk("hs_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_ready", 64'(cmd_ready), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);

        // Reset around tck 20 of the second scan
        repeat (40) tick();
        chk("mid_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_tck", 64'(tck), 64'd0);
        chk("mid_rst_tms", 64'(tms), 64'd1);
        chk("mid_rst_tdi", 64'(tdi), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd1);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_dr", 64'(rsp_dr), 64'd0);
        tick(); tick();
        reset = 1'b0;
        lat = 0; seen = 0;
        while (!cmd_ready && lat < 50) begin tick(); lat++; if (rsp_valid) seen = 1; end
        chk("reinit_latency", 64'(lat), 64'd12);
        repeat (20) begin tick(); if (rsp_valid) seen = 1; end
        chk("reinit_no_rsp", 64'(seen), 64'd0);

        // CLK_DIV=3 instance
        lat = 0;
        while (!cmd_ready3 && lat < 100) begin tick(); lat++; end
        chk("div3_ready", 64'(cmd_ready3), 64'd1);
        cmd_ir3 = 2'b01; cmd_dr3 = 38'h2A_AAAA_AAAA; cmd_valid3 = 1'b1;
        tick();
        cmd_valid3 = 1'b0;
        p_tck = tck3; p_tms = tms3; p_tdi = tdi3;
        lat = 0; r1 = 0; r2 = 0;
        while (!rsp_valid3 && lat < 400) begin
            tick();
            lat++;
            if (tck3 && !p_tck) begin
                if (r1 == 0) r1 = lat;
                else if (r2 == 0) r2 = lat;
            end
            if ((tms3 !== p_tms) || (tdi3 !== p_tdi)) chk("div3_fall_edge", 64'({p_tck, tck3}), 64'h2);
            p_tck = tck3; p_tms = tms3; p_tdi = tdi3;
        end
        chk("div3_latency", 64'(lat), 64'd300);
        chk("div3_first_rise", 64'(r1), 64'd3);
        chk("div3_period", 64'(r2 - r1), 64'd6);
        chk("div3_rsp_ir", 64'(rsp_ir3), 64'h3);
        chk("div3_rsp_dr", 64'(rsp_dr3), 64'h3F_FFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
